node_seq: RTL and testbench

NODE_SEQ -- requirements
Module: node_seq

---
 rtl/tis_pkg.sv | 31 +++
 rtl/node_seq_hs.sv | 43 ++++
 rtl/node_seq.sv | 167 ++++++++++++++++
 tb/tb_node_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tis_pkg.sv
// Shared types for the node sequencer: opcodes, source/destination codes and FSM states.
package tis_pkg;

    typedef enum logic [3:0] {
        OP_MOV = 4'h0,
        OP_JMP = 4'h1,
        OP_JEZ = 4'h2,
        OP_NOP = 4'h3
    } opcode_e;

    localparam logic [2:0] PORT0 = 3'b000;
    localparam logic [2:0] PORT1 = 3'b001;
    localparam logic [2:0] PORT2 = 3'b010;
    localparam logic [2:0] PORT3 = 3'b011;
    localparam logic [2:0] ACC   = 3'b100;
    localparam logic [2:0] NIL   = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        WAIT_RD,
        WAIT_WR
    } node_seq_state_e;

    // Codes 110/111 fall outside the port range and behave as NIL.
    function automatic logic is_port(input logic [2:0] code);
        return code <= PORT3;
    endfunction

endpackage

// File: rtl/node_seq_hs.sv
// Four-port one-hot handshake mux: turns a read/write request plus port codes into
// in_ready/out_valid strobes and reports read-done / write-done.
module node_seq_hs
    import tis_pkg::*;
(
    input  logic       rd_req_i,
    input  logic       wr_req_i,
    input  logic [2:0] src_i,
    input  logic [2:0] dst_i,
    input  logic [0:3] in_valid_i,
    input  logic [0:3] out_ready_i,
    output logic [0:3] in_ready_o,
    output logic [0:3] out_valid_o,
    output logic       rd_done_o,
    output logic       wr_done_o
);

    always_comb begin
        in_ready_o  = '0;
        out_valid_o = '0;
        rd_done_o   = 1'b0;
        wr_done_o   = 1'b0;
        if (rd_req_i) begin
            if (is_port(src_i)) begin
                if (in_valid_i[src_i[1:0]]) begin
                    in_ready_o[src_i[1:0]] = 1'b1;
                    rd_done_o              = 1'b1;
                end
            end else begin
                rd_done_o = 1'b1;
            end
        end
        if (wr_req_i) begin
            if (is_port(dst_i)) begin
                out_valid_o[dst_i[1:0]] = 1'b1;
                wr_done_o               = out_ready_i[dst_i[1:0]];
            end else begin
                wr_done_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/node_seq.sv
// Instruction sequencer for a single TIS node: fetch, decode MOV/JMP/JEZ/NOP, port handshakes.
// Optional stall watchdog enabled by defining NODE_SEQ_TIMEOUT_EN.
module node_seq
    import tis_pkg::*;
#(
    parameter int unsigned PROG_LEN = 16,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [0:7]  addr_instr,
    input  logic [0:17] instr,
    input  logic [0:3]  in_valid,
    output logic [0:3]  in_ready,
    output logic [0:3]  out_valid,
    input  logic [0:3]  out_ready,
    input  logic        acc_zero,
    output logic [0:2]  src_sel,
    output logic [0:2]  dst_sel,
    output logic        rd_en,
    output logic        wr_en,
    output logic        busy,
    output logic        stall_timeout
);

    localparam int unsigned PC_W = 8;
    localparam int unsigned IW   = 18;

    node_seq_state_e state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IW-1:0]   ir_q, ir_d;

    opcode_e         op;
    logic [2:0]      src, dst;
    logic [PC_W-1:0] tgt;
    logic            rd_req, wr_req, rd_done, wr_done;
    logic            commit, take_jump;

    // Instruction register fields, MSB-first as in the instruction word.
    assign op  = opcode_e'(ir_q[17:14]);
    assign dst = ir_q[13:11];
    assign src = ir_q[10:8];
    assign tgt = ir_q[7:0];

    assign rd_req = ((state_q == EXEC) && (op == OP_MOV)) || (state_q == WAIT_RD);
    assign wr_req = (state_q == WAIT_WR);

    node_seq_hs u_hs (
        .rd_req_i    (rd_req),
        .wr_req_i    (wr_req),
        .src_i       (src),
        .dst_i       (dst),
        .in_valid_i  (in_valid),
        .out_ready_i (out_ready),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .rd_done_o   (rd_done),
        .wr_done_o   (wr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        commit    = 1'b0;
        take_jump = 1'b0;
        case (state_q)
            IDLE:    if (run) state_d = FETCH;
            FETCH: begin
                ir_d    = instr;
                state_d = EXEC;
            end
            EXEC: begin
                case (op)
                    OP_MOV:  if (!rd_done) state_d = WAIT_RD;
                    OP_JMP: begin
                        commit    = 1'b1;
                        take_jump = 1'b1;
                    end
                    OP_JEZ: begin
                        commit    = 1'b1;
                        take_jump = acc_zero;
                    end
                    default: commit = 1'b1;
                endcase
            end
            WAIT_RD: ;
            WAIT_WR: commit = wr_done;
            default: state_d = IDLE;
        endcase
        // Read completes: port destinations wait for the consumer, others commit now.
        if (rd_req && rd_done) begin
            rd_en = 1'b1;
            if (is_port(dst)) begin
                state_d = WAIT_WR;
            end else begin
                wr_en  = 1'b1;
                commit = 1'b1;
            end
        end
        if (commit) begin
            if (take_jump) begin
                pc_d = (32'(tgt) < PROG_LEN) ? tgt : '0;
            end else begin
                pc_d = (32'(pc_q) == PROG_LEN - 1) ? '0 : pc_q + PC_W'(1);
            end
            state_d = run ? FETCH : IDLE;
        end
    end

    assign addr_instr = pc_q;
    assign src_sel    = src;
    assign dst_sel    = dst;
    assign busy       = (state_q != IDLE);

`ifdef NODE_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 2);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             timeout_q, timeout_d;
    logic             stalling;

    assign stalling = (state_q == WAIT_RD) || (state_q == WAIT_WR);

    // Saturating count of consecutive stall cycles; the flag is sticky until reset.
    always_comb begin
        stall_cnt_d = '0;
        timeout_d   = timeout_q;
        if (stalling) begin
            if (32'(stall_cnt_q) + 32'd1 >= TIMEOUT) timeout_d = 1'b1;
            if (!commit) begin
                stall_cnt_d = (32'(stall_cnt_q) < TIMEOUT) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;
`else
    assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_node_seq.sv
// Scoreboard bench for node_seq: per-cycle expected observations are queued as stimulus is applied.
module tb_node_seq;

    typedef struct packed {
        logic       busy;
        logic [7:0] addr;
        logic [3:0] ir;
        logic [3:0] ov;
        logic       rd;
        logic       wr;
        logic [2:0] src;
        logic [2:0] dst;
        logic       to;
    } obs_t;

    typedef struct packed {
        logic       run;
        logic [3:0] iv;
        logic [3:0] ordy;
        logic       az;
        obs_t       exp;
    } stim_t;

`ifdef NODE_SEQ_TIMEOUT_EN
    localparam logic TO_EXP = 1'b1;
`else
    localparam logic TO_EXP = 1'b0;
`endif

    logic        clk, rst, run, acc_zero;
    logic [0:7]  addr_instr;
    logic [0:17] instr;
    logic [0:3]  in_valid, in_ready, out_valid, out_ready;
    logic [0:2]  src_sel, dst_sel;
    logic        rd_en, wr_en, busy, stall_timeout;

    logic [17:0] rom [0:255];
    obs_t        exp_q[$];
    int          vectors;
    int          miscompares;

    node_seq #(.PROG_LEN(16), .TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .addr_instr    (addr_instr),
        .instr         (instr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .acc_zero      (acc_zero),
        .src_sel       (src_sel),
        .dst_sel       (dst_sel),
        .rd_en         (rd_en),
        .wr_en         (wr_en),
        .busy          (busy),
        .stall_timeout (stall_timeout)
    );

    assign instr = rom[addr_instr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] w(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s,
                                      input logic [7:0] t);
        return {op, d, s, t};
    endfunction

    function automatic obs_t ob(input logic b, input logic [7:0] a, input logic [3:0] ir, input logic [3:0] ov,
                                input logic rd, input logic wr, input logic [2:0] s, input logic [2:0] d,
                                input logic to);
        return {b, a, ir, ov, rd, wr, s, d, to};
    endfunction

    function automatic stim_t rw(input logic r, input logic [3:0] iv, input logic [3:0] ordy, input logic az,
                                 input obs_t e);
        return {r, iv, ordy, az, e};
    endfunction

    function automatic obs_t sample();
        return {busy, addr_instr, in_ready, out_valid, rd_en, wr_en, src_sel, dst_sel, stall_timeout};
    endfunction

    task automatic test_reset();
        obs_t got, want;
        rst = 1'b1; run = 1'b0; in_valid = '0; out_ready = '0; acc_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(ob(0, 8'd0, 4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0));
        got = sample(); want = exp_q.pop_front();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL reset got=%h want=%h", got, want);
        end
        rst = 1'b0; run = 1'b1;
    endtask

    task automatic test_mov_ports();
        stim_t rows[$];
        obs_t  got, want;
        rom[0] = w(4'h0, 3'b010, 3'b001, 8'h00);
        rom[1] = w(4'h3, 3'b000, 3'b000, 8'h00);
        rows.push_back(rw(0, 4'b0000, 4'b0000, 0, ob(1, 8'd0, 4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(1, 8'd0, 4'b0000, 4'b0000, 0, 0, 3'd1, 3'd2, 0)));
        rows.push_back(rw(1, 4'b1011, 4'b0000, 0, ob(1, 8'd0, 4'b0000, 4'b0000, 0, 0, 3'd1, 3'd2, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(1, 8'd0, 4'b0000, 4'b0000, 0, 0, 3'd1, 3'd2, 0)));
        rows.push_back(rw(1, 4'b0100, 4'b0000, 0, ob(1, 8'd0, 4'b0100, 4'b0000, 1, 0, 3'd1, 3'd2, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(1, 8'd0, 4'b0000, 4'b0010, 0, 0, 3'd1, 3'd2, 0)));
        rows.push_back(rw(1, 4'b0100, 4'b1101, 0, ob(1, 8'd0, 4'b0000, 4'b0010, 0, 0, 3'd1, 3'd2, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0010, 0, ob(1, 8'd0, 4'b0000, 4'b0010, 0, 0, 3'd1, 3'd2, 0)));
        rows.push_back(rw(0, 4'b0000, 4'b0000, 0, ob(1, 8'd1, 4'b0000, 4'b0000, 0, 0, 3'd1, 3'd2, 0)));
        rows.push_back(rw(0, 4'b0000, 4'b0000, 0, ob(1, 8'd1, 4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0)));
        rows.push_back(rw(0, 4'b0000, 4'b0000, 0, ob(0, 8'd2, 4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0)));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            run = rows[i].run; in_valid = rows[i].iv; out_ready = rows[i].ordy; acc_zero = rows[i].az;
            exp_q.push_back(rows[i].exp);
            #1;
            got = sample(); want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL mov_ports[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_acc_nil_wrap();
        stim_t rows[$];
        obs_t  got, want;
        rom[2]  = w(4'h1, 3'b000, 3'b000, 8'h0F);
        rom[15] = w(4'h0, 3'b101, 3'b100, 8'h00);
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(0, 8'd2,  4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(1, 8'd2,  4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(1, 8'd2,  4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(1, 8'd15, 4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0)));
        rows.push_back(rw(0, 4'b1111, 4'b0000, 0, ob(1, 8'd15, 4'b0000, 4'b0000, 1, 1, 3'd4, 3'd5, 0)));
        rows.push_back(rw(0, 4'b0000, 4'b0000, 0, ob(0, 8'd0,  4'b0000, 4'b0000, 0, 0, 3'd4, 3'd5, 0)));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            run = rows[i].run; in_valid = rows[i].iv; out_ready = rows[i].ordy; acc_zero = rows[i].az;
            exp_q.push_back(rows[i].exp);
            #1;
            got = sample(); want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL acc_nil_wrap[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_jumps();
        stim_t rows[$];
        obs_t  got, want;
        rom[0] = w(4'h2, 3'b000, 3'b000, 8'h05);
        rom[5] = w(4'h2, 3'b000, 3'b000, 8'h05);
        rom[6] = w(4'h1, 3'b000, 3'b000, 8'h20);
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(0, 8'd0, 4'b0000, 4'b0000, 0, 0, 3'd4, 3'd5, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(1, 8'd0, 4'b0000, 4'b0000, 0, 0, 3'd4, 3'd5, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 1, ob(1, 8'd0, 4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(1, 8'd5, 4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(1, 8'd5, 4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(1, 8'd6, 4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0)));
        rows.push_back(rw(0, 4'b0000, 4'b0000, 0, ob(1, 8'd6, 4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0)));
        rows.push_back(rw(0, 4'b0000, 4'b0000, 0, ob(0, 8'd0, 4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0)));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            run = rows[i].run; in_valid = rows[i].iv; out_ready = rows[i].ordy; acc_zero = rows[i].az;
            exp_q.push_back(rows[i].exp);
            #1;
            got = sample(); want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL jumps[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t rows[$];
        obs_t  got, want;
        rom[0] = w(4'h1, 3'b000, 3'b000, 8'h03);
        rom[3] = w(4'h0, 3'b011, 3'b100, 8'h00);
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(0, 8'd0, 4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(1, 8'd0, 4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(1, 8'd0, 4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(1, 8'd3, 4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(1, 8'd3, 4'b0000, 4'b0000, 1, 0, 3'd4, 3'd3, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(1, 8'd3, 4'b0000, 4'b0001, 0, 0, 3'd4, 3'd3, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b1110, 0, ob(1, 8'd3, 4'b0000, 4'b0001, 0, 0, 3'd4, 3'd3, 0)));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            run = rows[i].run; in_valid = rows[i].iv; out_ready = rows[i].ordy; acc_zero = rows[i].az;
            exp_q.push_back(rows[i].exp);
            #1;
            got = sample(); want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset_mid[%0d] got=%h want=%h", i, got, want);
            end
        end
        // Mid-cycle reset while out_valid is held: everything must clear without a clock edge.
        @(posedge clk); #1;
        out_ready = '0; run = 1'b0;
        #1;
        rst = 1'b1;
        exp_q.push_back(ob(0, 8'd0, 4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0));
        #1;
        got = sample(); want = exp_q.pop_front();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL reset_mid_async got=%h want=%h", got, want);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(ob(0, 8'd0, 4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0));
        #1;
        got = sample(); want = exp_q.pop_front();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL reset_mid_idle got=%h want=%h", got, want);
        end
    endtask

    task automatic test_timeout();
        stim_t rows[$];
        obs_t  got, want;
        rom[0] = w(4'h0, 3'b000, 3'b100, 8'h00);
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(0, 8'd0, 4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(1, 8'd0, 4'b0000, 4'b0000, 0, 0, 3'd0, 3'd0, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(1, 8'd0, 4'b0000, 4'b0000, 1, 0, 3'd4, 3'd0, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(1, 8'd0, 4'b0000, 4'b1000, 0, 0, 3'd4, 3'd0, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(1, 8'd0, 4'b0000, 4'b1000, 0, 0, 3'd4, 3'd0, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(1, 8'd0, 4'b0000, 4'b1000, 0, 0, 3'd4, 3'd0, 0)));
        rows.push_back(rw(1, 4'b0000, 4'b0000, 0, ob(1, 8'd0, 4'b0000, 4'b1000, 0, 0, 3'd4, 3'd0, 0)));
        rows.push_back(rw(0, 4'b0000, 4'b1000, 0, ob(1, 8'd0, 4'b0000, 4'b1000, 0, 0, 3'd4, 3'd0, TO_EXP)));
        rows.push_back(rw(0, 4'b0000, 4'b0000, 0, ob(0, 8'd1, 4'b0000, 4'b0000, 0, 0, 3'd4, 3'd0, TO_EXP)));
        rows.push_back(rw(0, 4'b0000, 4'b0000, 0, ob(0, 8'd1, 4'b0000, 4'b0000, 0, 0, 3'd4, 3'd0, TO_EXP)));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            run = rows[i].run; in_valid = rows[i].iv; out_ready = rows[i].ordy; acc_zero = rows[i].az;
            exp_q.push_back(rows[i].exp);
            #1;
            got = sample(); want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL timeout[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int a = 0; a < 256; a++) rom[a] = w(4'h3, 3'b000, 3'b000, 8'h00);
        test_reset();
        test_mov_ports();
        test_acc_nil_wrap();
        test_jumps();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
